// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; decode also uses NOP_INSN.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;
  localparam logic [31:0] DEFAULT_MEM_BASE = 32'h0100_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imemory, pairs each word with its PC
// and hands {pc, insn} to decode under a valid/stall handshake.
//
// state | meaning
// RUN   | streaming; f_insn comes straight from imem_data_out
// HOLD  | decode stalled; f_insn replayed from hold_q
// FAULT | illegal fetch address on f_pc; NOP presented until a redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] MEM_BASE  = DEFAULT_MEM_BASE,
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_insn,
  output logic        f_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [31:0]  hold_q, hold_d;
  logic         advance;

  // 33-bit bounds so MEM_BASE + MEM_BYTES cannot wrap
  function automatic logic addr_legal(input logic [31:0] addr);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, MEM_BASE};
    hi = {1'b0, MEM_BASE} + 33'(MEM_BYTES) - 33'd4;
    return (addr[1:0] == 2'b00) && ({1'b0, addr} >= lo) && ({1'b0, addr} <= hi);
  endfunction

  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = 32'h0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
      hold_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    hold_d      = hold_q;
    advance     = 1'b0;
    f_valid     = rsp_valid_q;
    f_pc        = rsp_pc_q;
    f_insn      = imem_data_out;
    f_fault     = 1'b0;

    case (state_q)
      RUN: begin
        if (stall && rsp_valid_q) begin
          hold_d  = imem_data_out;
          state_d = HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      HOLD: begin
        f_valid = 1'b1;
        f_insn  = hold_q;
        advance = !stall;
      end
      FAULT: begin
        f_valid = 1'b1;
        f_fault = 1'b1;
        f_insn  = NOP_INSN;
      end
      default: state_d = RUN;
    endcase

    // memory keeps re-reading pc_q while held, so advancing here stays aligned
    if (advance) begin
      rsp_pc_d    = pc_q;
      rsp_valid_d = 1'b1;
      if (addr_legal(pc_q)) begin
        pc_d    = pc_q + 32'd4;
        state_d = RUN;
      end else begin
        state_d = FAULT;
      end
    end

    if (redirect_valid) begin
      pc_d        = redirect_target;
      rsp_valid_d = 1'b0;
      state_d     = RUN;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based scoreboard of expected {pc, insn, fault}.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned BYTES = 1048576;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_insn;
  logic        f_fault;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(BASE), .MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_address(imem_address), .imem_read_write(imem_read_write),
    .imem_data_in(imem_data_in), .imem_data_out(imem_data_out),
    .f_valid(f_valid), .f_pc(f_pc), .f_insn(f_insn), .f_fault(f_fault)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // synchronous-read instruction memory
  always @(posedge clock) imem_data_out <= img(imem_address);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } exp_t;

  exp_t        q[$];
  logic [31:0] gen_pc;
  bit          gen_faulted;
  bit          bubble;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x % 4 == 0) && (x >= 64'(BASE)) && (x + 4 <= 64'(BASE) + 64'(BYTES));
  endfunction

  // expected stream: consecutive words from gen_pc until the first illegal one, which repeats
  task automatic refill();
    exp_t e;
    while (q.size() < 2) begin
      e.pc = gen_pc;
      if (gen_faulted || !legal(gen_pc)) begin
        e.insn = NOP_INSN;
        e.fault = 1'b1;
        gen_faulted = 1'b1;
      end else begin
        e.insn = img(gen_pc);
        e.fault = 1'b0;
        gen_pc = gen_pc + 32'd4;
      end
      q.push_back(e);
    end
  endtask

  // monitor: inputs are changed just after posedge, so negedge values are what the next edge samples
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      gen_pc = BASE;
      gen_faulted = 1'b0;
      bubble = 1'b1;
    end else begin
      chk("mon_valid", {31'b0, f_valid}, {31'b0, !bubble});
      if (f_valid && !bubble) begin
        refill();
        chk("mon_pc", f_pc, q[0].pc);
        chk("mon_insn", f_insn, q[0].insn);
        chk("mon_fault", {31'b0, f_fault}, {31'b0, q[0].fault});
      end
      if (redirect_valid) begin
        q.delete();
        gen_pc = redirect_target;
        gen_faulted = 1'b0;
        bubble = 1'b1;
      end else begin
        bubble = 1'b0;
        if (f_valid && !stall && q.size() > 0) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] addr);
    for (int i = 0; i < 40; i++) begin
      if (f_valid && f_pc == addr) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_pc: timed out waiting for f_pc %h, last f_pc %h", addr, f_pc);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_target = target;
    step();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'b0, f_valid}, 32'd0);
    step();
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'b0, f_valid}, 32'd0);
    chk("rst_fault", {31'b0, f_fault}, 32'd0);
    chk("rst_pc", f_pc, BASE);
    chk("rst_addr", imem_address, BASE);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    chk("rst_rw", {31'b0, imem_read_write}, 32'd0);
    chk("rst_din", imem_data_in, 32'd0);
    reset_n = 1'b1;
    step();
    chk("first_valid", {31'b0, f_valid}, 32'd1);
    chk("first_pc", f_pc, BASE);

    wait_pc(BASE + 32'h8);
    stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_pc", f_pc, BASE + 32'h8);
      chk("stall_insn", f_insn, img(BASE + 32'h8));
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", f_pc, BASE + 32'hC);

    wait_pc(BASE + 32'h10);
    redirect(BASE + 32'h100);
    chk("redir_pc", f_pc, BASE + 32'h100);

    redirect(BASE + 32'h102);
    chk("misalign_fault", {31'b0, f_fault}, 32'd1);
    chk("misalign_pc", f_pc, BASE + 32'h102);
    chk("misalign_insn", f_insn, NOP_INSN);
    stall = 1'b1;
    step();
    stall = 1'b0;
    repeat (2) step();
    chk("fault_sticky", {31'b0, f_fault}, 32'd1);
    redirect(BASE);
    chk("resume_pc", f_pc, BASE);
    chk("resume_fault", {31'b0, f_fault}, 32'd0);

    redirect(32'h010F_FFF0);
    wait_pc(32'h010F_FFFC);
    chk("last_word_fault", {31'b0, f_fault}, 32'd0);
    step();
    chk("end_fault", {31'b0, f_fault}, 32'd1);
    chk("end_pc", f_pc, 32'h0110_0000);

    redirect(32'h00FF_FFFC);
    chk("below_fault", {31'b0, f_fault}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 5) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 4))
          0: redirect_target = BASE + 32'($urandom_range(0, 63) * 4);
          1: redirect_target = BASE + 32'(BYTES) - 32'd16 + 32'($urandom_range(0, 3) * 4);
          2: redirect_target = BASE + (32'($urandom_range(0, 255)) | 32'd1);
          3: redirect_target = BASE - 32'($urandom_range(1, 4) * 4);
          default: redirect_target = BASE + 32'(BYTES) + 32'($urandom_range(0, 4) * 4);
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;

    redirect(BASE + 32'h40);
    wait_pc(BASE + 32'h40);
    stall = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    stall = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("restart_valid", {31'b0, f_valid}, 32'd1);
    chk("restart_pc", f_pc, BASE);
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RISC-V core, sitting directly upstream of `imemory`. Owns the PC, drives the instruction memory's address/read port, pairs each returned instruction word with its PC, and hands `{pc, insn}` to decode under a valid/stall handshake. Handles branch/jump redirects from later stages, squashes the word already in flight, and flags misaligned or out-of-range fetch addresses.

## Interface
Parameters:
- `RESET_PC`, 32'h0100_0000: first fetch address after reset.
- `MEM_BASE`, 32'h0100_0000: lowest legal instruction byte address.
- `MEM_BYTES`, 1048576: instruction memory size in bytes; legal range is [MEM_BASE, MEM_BASE+MEM_BYTES-4].

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: decode cannot accept this cycle.
- `redirect_valid` in 1: later stage requests a PC change.
- `redirect_target` in 32: new fetch byte address.
- `imem_address` out 32: address to `imemory`.
- `imem_read_write` out 1: tied 0 (read only).
- `imem_data_in` out 32: tied 0.
- `imem_data_out` in 32: word from `imemory`, registered there on the same edge that samples `imem_address`.
- `f_valid` out 1: `f_pc`/`f_insn` hold a real instruction.
- `f_pc` out 32: PC of `f_insn`.
- `f_insn` out 32: instruction word.
- `f_fault` out 1: fetch fault on `f_pc` (misaligned or out of range); `f_insn` is then NOP 32'h0000_0013.

## Operation
- Registers: `pc_q` (next address to fetch), `rsp_pc_q` (address of the word currently on `imem_data_out`), `rsp_valid_q`, `hold_q` (32-bit instruction capture), `state_q` ∈ {RUN, HOLD, FAULT}.
- `imem_address = pc_q` at all times. A transfer is accepted on an edge where `f_valid=1 && stall=0`.
- RUN: `f_insn=imem_data_out`, `f_pc=rsp_pc_q`, `f_valid=rsp_valid_q`, `f_fault=0`.
  - Advance, taken when `!(stall && f_valid)`: `rsp_pc_q<=pc_q`, `rsp_valid_q<=1`, `pc_q<=pc_q+4` (32-bit modulo wrap).
  - Advance with `pc_q` illegal (`pc_q[1:0]!=0`, or outside the legal range): `rsp_pc_q<=pc_q`, `rsp_valid_q<=1`, go to FAULT, `pc_q` unchanged.
  - `stall && f_valid`: `hold_q<=imem_data_out`, go to HOLD. `pc_q` and `rsp_pc_q` are unchanged.
- HOLD: `f_insn=hold_q`, `f_valid=1`, `f_pc=rsp_pc_q`. While `stall=1`, stay in HOLD. When `stall=0`, perform the RUN advance (or enter FAULT) and return to RUN. The memory has been re-reading `pc_q` throughout, so the data stays aligned.
- FAULT: `f_valid=1`, `f_fault=1`, `f_insn=32'h0000_0013`, `f_pc=rsp_pc_q`. Stays in FAULT until a redirect, whether or not `stall` is asserted. No advance.
- Redirect, highest priority in every state: `pc_q<=redirect_target`, `rsp_valid_q<=0`, state goes to RUN. The in-flight or held word is discarded, even if it would otherwise be accepted on that edge. A misaligned or out-of-range target faults one edge later through the normal RUN path.
- Arithmetic: the range check uses 33-bit compares, so `MEM_BASE+MEM_BYTES` cannot overflow.

## Timing
- Reset (async assert, sync release): `pc_q=RESET_PC`, `rsp_pc_q=RESET_PC`, `rsp_valid_q=0`, `hold_q=0`, state RUN.
- Output values during reset: `f_valid=0`, `f_fault=0`, `f_pc=RESET_PC`, `imem_address=RESET_PC`.
- First edge after release: memory reads `RESET_PC`. `f_valid=1` with `f_pc=RESET_PC` follows that edge, i.e. 1 cycle of latency.
- Throughput: one instruction per cycle when `stall=0`.
- Redirect: sampled on edge N. Edge N+1 reads the target. `f_valid=1, f_pc=target` holds after edge N+1. Exactly one bubble cycle (`f_valid=0`) follows edge N.
- Stall: outputs are stable and identical while `stall=1`. After the edge on which stall drops, the next sequential PC appears with no bubble.
- Reset asserted mid-stall or in FAULT returns to the reset state immediately.

## Structure
- Shared package `fetch_pkg`: the `fetch_state_t` enum {RUN, HOLD, FAULT}, `NOP_INSN = 32'h0000_0013`, and the default `RESET_PC`/`MEM_BASE` constants. Decode reuses `NOP_INSN`.
- Single module; no sub-module needed. The address-legality check is a local combinational function.

## Test plan
- Reset release, `stall=0`: `f_pc` sequence 0x01000000, 0x01000004, 0x01000008, …; `f_insn` matches the memory image; first `f_valid` is 1 cycle after release.
- `stall` high for 3 cycles while `f_pc=0x01000008`: `f_pc`/`f_insn` are frozen. After release, 0x0100000C follows with no bubble and no duplicate.
- Redirect to 0x01000100 on the same edge that 0x01000010 would be accepted: 0x01000010 is squashed, one `f_valid=0` cycle follows, then 0x01000100, 0x01000104.
- Redirect to 0x01000102: after one bubble, `f_valid=1, f_fault=1, f_pc=0x01000102, f_insn=0x00000013`, held until a redirect to 0x01000000 resumes normal fetch.
- Sequential fetch reaching `MEM_BASE+MEM_BYTES` (0x01100000): FAULT with `f_pc=0x01100000`. The last legal word 0x010FFFFC is delivered normally.
- `reset_n` asserted during HOLD: outputs go to their reset values asynchronously, and fetch restarts at `RESET_PC`.
